// File: rtl/trace_playback_ctrl_if.sv
// Purpose : groups the playback controller's config, control, pattern-RAM read
//           port and trace outputs into one bundle.
// Ports   : master = controller side (drives RAM reads and trace outputs);
//           slave  = environment side (drives config/control, returns RAM data).
interface trace_playback_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    // configuration, sampled only on an accepted start
    logic [ADDR_W-1:0] cfg_start_addr;
    logic [ADDR_W:0]   cfg_length;
    logic [CNT_W-1:0]  cfg_repeat;
    logic [ADDR_W:0]   cfg_trig_offset;
    logic [DATA_W-1:0] cfg_idle_data;
    // control
    logic              start;
    logic              abort;
    // pattern RAM read port (1-cycle read latency)
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    // trace output and status
    logic [DATA_W-1:0] TRACEDATA;
    logic              trig_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_count;

    modport master (
        input  cfg_start_addr, cfg_length, cfg_repeat, cfg_trig_offset, cfg_idle_data,
        input  start, abort, mem_rd_data,
        output mem_rd_en, mem_rd_addr,
        output TRACEDATA, trig_out, busy, done, pass_count
    );

    modport slave (
        output cfg_start_addr, cfg_length, cfg_repeat, cfg_trig_offset, cfg_idle_data,
        output start, abort, mem_rd_data,
        input  mem_rd_en, mem_rd_addr,
        input  TRACEDATA, trig_out, busy, done, pass_count
    );
endinterface

// File: rtl/trace_playback_ctrl.sv
// Purpose     : replays a windowed 4-bit trace pattern from a synchronous RAM onto
//               TRACEDATA with repeat count, trigger marker and start/abort/done.
// Latency     : first read at T+1 after start at T, first nibble at T+3, done one
//               cycle after the final nibble; read-to-TRACEDATA is fixed at 2 cycles.
// Backpressure: none; the RAM must accept a read every cycle while running.
// Ports       : clk, reset (sync, active-high), bus (trace_playback_ctrl_if.master):
//               cfg_* window/repeat/trigger/idle config, start/abort control,
//               mem_rd_* RAM read port, TRACEDATA/trig_out/busy/done/pass_count.
module trace_playback_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    trace_playback_ctrl_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state;

    // configuration captured at start
    logic [ADDR_W-1:0] start_addr_q;
    logic [ADDR_W:0]   length_q;
    logic [CNT_W-1:0]  repeat_q;
    logic [ADDR_W:0]   trig_q;
    logic [DATA_W-1:0] idle_q;

    // read-side sequencing
    logic [ADDR_W:0]   idx;
    logic [CNT_W-1:0]  rd_pass;
    logic              flush_cnt;

    // tags travelling alongside the RAM read (aligned with mem_rd_data)
    logic              s1_vld;
    logic              s1_last;
    logic              s1_trig;

    // registered outputs
    logic [DATA_W-1:0] trace_q;
    logic              trig_out_q;
    logic              done_q;
    logic [CNT_W-1:0]  pass_q;

    logic              run;
    logic              last_idx;
    logic              last_pass;
    logic              busy_abort;

    assign run        = (state == ST_RUN);
    assign last_idx   = (idx == (length_q - 1'b1));
    // repeat of 0 means loop forever, so the final pass is never reached
    assign last_pass  = (repeat_q != '0) && (rd_pass == (repeat_q - 1'b1));
    assign busy_abort = bus.abort && (state != ST_IDLE);

    assign bus.mem_rd_en   = run;
    // address is held at 0 outside RUN so the port is quiet between runs;
    // the add truncates, giving the required wrap at the top of the RAM
    assign bus.mem_rd_addr = run ? (start_addr_q + idx[ADDR_W-1:0]) : '0;
    assign bus.TRACEDATA   = trace_q;
    assign bus.trig_out    = trig_out_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.pass_count  = pass_q;

    // control FSM and read sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            start_addr_q <= '0;
            length_q     <= '0;
            repeat_q     <= '0;
            trig_q       <= '0;
            idle_q       <= '0;
            idx          <= '0;
            rd_pass      <= '0;
            flush_cnt    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort presented together with start cancels the request
                    if (bus.start && !bus.abort) begin
                        start_addr_q <= bus.cfg_start_addr;
                        length_q     <= bus.cfg_length;
                        repeat_q     <= bus.cfg_repeat;
                        trig_q       <= bus.cfg_trig_offset;
                        idle_q       <= bus.cfg_idle_data;
                        idx          <= '0;
                        rd_pass      <= '0;
                        if (bus.cfg_length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else if (last_idx) begin
                        idx <= '0;
                        if (last_pass) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b0;
                        end else begin
                            rd_pass <= rd_pass + 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // two cycles: data stage then output stage
                    if (bus.abort || flush_cnt) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // data path: tags follow the read by one cycle, output register one more
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            s1_trig    <= 1'b0;
            trace_q    <= '0;
            trig_out_q <= 1'b0;
            pass_q     <= '0;
        end else begin
            // a read issued in the abort cycle must never reach the output
            s1_vld  <= run && !bus.abort;
            s1_last <= last_idx;
            s1_trig <= (idx == trig_q);

            if (s1_vld && !busy_abort) begin
                trace_q    <= bus.mem_rd_data;
                trig_out_q <= s1_trig;
                if (s1_last && (pass_q != '1)) begin
                    pass_q <= pass_q + 1'b1;
                end
            end else begin
                // idle value tracks the live input only when no run is active
                trace_q    <= (state == ST_IDLE) ? bus.cfg_idle_data : idle_q;
                trig_out_q <= 1'b0;
            end

            if ((state == ST_IDLE) && bus.start && !bus.abort) begin
                pass_q <= '0;
            end
        end
    end

endmodule
